id_decode_queue: RTL and testbench

- Parametrised instruction queue plus 3R/shift-immediate decoder for the ID stage.
- Accepts fetched (pc, inst) pairs over a valid/ready handshake and decodes each instruction when it is enqueued.
- Stores the decoded bundles in a DEPTH-entry circular buffer and presents the head to the issue logic over a second valid/ready handshake.
- Supports a single-cycle flush for branch redirect and exceptions.

---
 rtl/id_decode_queue.sv | 160 ++++++++++++++++
 tb/tb_id_decode_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_queue.sv
// ID-stage instruction queue: decodes 3R/shift-immediate instructions on enqueue into a DEPTH-entry FIFO.
// Optional macro DECODE_INE_EN flags OP_INVALID head entries on out_ine.
package id_decode_queue_pkg;
  localparam logic [7:0] OP_INVALID = 8'd0;
  localparam logic [7:0] OP_ADD     = 8'd1;
  localparam logic [7:0] OP_SUB     = 8'd2;
  localparam logic [7:0] OP_SLT     = 8'd3;
  localparam logic [7:0] OP_SLTU    = 8'd4;
  localparam logic [7:0] OP_NOR     = 8'd5;
  localparam logic [7:0] OP_AND     = 8'd6;
  localparam logic [7:0] OP_OR      = 8'd7;
  localparam logic [7:0] OP_XOR     = 8'd8;
  localparam logic [7:0] OP_SLL     = 8'd9;
  localparam logic [7:0] OP_SRL     = 8'd10;
  localparam logic [7:0] OP_SRA     = 8'd11;
  localparam logic [7:0] OP_MUL     = 8'd12;
  localparam logic [7:0] OP_MULH    = 8'd13;
  localparam logic [7:0] OP_MULHU   = 8'd14;
  localparam logic [7:0] OP_DIV     = 8'd15;
  localparam logic [7:0] OP_MOD     = 8'd16;
  localparam logic [7:0] OP_DIVU    = 8'd17;
  localparam logic [7:0] OP_MODU    = 8'd18;
  localparam logic [7:0] OP_BREAK   = 8'd19;
  localparam logic [7:0] OP_SYSCALL = 8'd20;
  localparam logic [7:0] OP_SLLI    = 8'd21;
  localparam logic [7:0] OP_SRLI    = 8'd22;
  localparam logic [7:0] OP_SRAI    = 8'd23;
endpackage

module id_decode_queue
  import id_decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OP_W  = 8,
  parameter int PC_W  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PC_W-1:0]              in_pc,
  input  logic [31:0]                  in_inst,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OP_W-1:0]              out_op,
  output logic [4:0]                   out_rd,
  output logic [4:0]                   out_rj,
  output logic [4:0]                   out_rk,
  output logic                         out_src2_imm,
  output logic [PC_W-1:0]              out_pc,
  output logic [31:0]                  out_inst,
  output logic                         out_ine,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [OP_W-1:0] r_op_mem   [DEPTH];
  logic            r_imm_mem  [DEPTH];
  logic [PC_W-1:0] r_pc_mem   [DEPTH];
  logic [31:0]     r_inst_mem [DEPTH];

  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [7:0]      w_op8;
  logic [OP_W-1:0] w_op;
  logic            w_imm;
  logic            w_push;
  logic            w_pop;

  always_comb begin
    w_op8 = OP_INVALID;
    if (in_inst[31:23] == 9'd0) begin
      case (in_inst[22:15])
        8'h20: w_op8 = OP_ADD;
        8'h22: w_op8 = OP_SUB;
        8'h24: w_op8 = OP_SLT;
        8'h25: w_op8 = OP_SLTU;
        8'h28: w_op8 = OP_NOR;
        8'h29: w_op8 = OP_AND;
        8'h2A: w_op8 = OP_OR;
        8'h2B: w_op8 = OP_XOR;
        8'h2E: w_op8 = OP_SLL;
        8'h2F: w_op8 = OP_SRL;
        8'h30: w_op8 = OP_SRA;
        8'h38: w_op8 = OP_MUL;
        8'h39: w_op8 = OP_MULH;
        8'h3A: w_op8 = OP_MULHU;
        8'h40: w_op8 = OP_DIV;
        8'h41: w_op8 = OP_MOD;
        8'h42: w_op8 = OP_DIVU;
        8'h43: w_op8 = OP_MODU;
        8'h54: w_op8 = OP_BREAK;
        8'h56: w_op8 = OP_SYSCALL;
        8'h81: w_op8 = OP_SLLI;
        8'h89: w_op8 = OP_SRLI;
        8'h91: w_op8 = OP_SRAI;
        default: w_op8 = OP_INVALID;
      endcase
    end
  end

  assign w_op  = OP_W'(w_op8);
  assign w_imm = (w_op8 == OP_SLLI) || (w_op8 == OP_SRLI) || (w_op8 == OP_SRAI);

  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  // Payload storage is deliberately unreset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op_mem[r_wr_ptr]   <= w_op;
      r_imm_mem[r_wr_ptr]  <= w_imm;
      r_pc_mem[r_wr_ptr]   <= in_pc;
      r_inst_mem[r_wr_ptr] <= in_inst;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_op       = r_op_mem[r_rd_ptr];
  assign out_src2_imm = r_imm_mem[r_rd_ptr];
  assign out_pc       = r_pc_mem[r_rd_ptr];
  assign out_inst     = r_inst_mem[r_rd_ptr];
  assign out_rd       = out_inst[4:0];
  assign out_rj       = out_inst[9:5];
  assign out_rk       = out_inst[14:10];
  assign count        = r_count;

`ifdef DECODE_INE_EN
  assign out_ine = out_valid & (out_op == OP_W'(OP_INVALID));
`else
  assign out_ine = 1'b0;
`endif

endmodule

// File: tb/tb_id_decode_queue.sv
// Self-checking bench for id_decode_queue: directed scenarios plus randomized traffic against a queue model.
module tb_id_decode_queue;
  import id_decode_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_src2_imm, out_ine;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic [7:0]  out_op;
  logic [4:0]  out_rd, out_rj, out_rk;
  logic [2:0]  count;

  id_decode_queue #(.DEPTH(DEPTH), .OP_W(8), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rd(out_rd), .out_rj(out_rj), .out_rk(out_rk), .out_src2_imm(out_src2_imm),
    .out_pc(out_pc), .out_inst(out_inst), .out_ine(out_ine), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t mq[$];
  logic [7:0] op_tab [256];
  logic [7:0] funcs [23];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [7:0] ref_op(input logic [31:0] inst);
    if (inst[31:23] != 0) return OP_INVALID;
    return op_tab[inst[22:15]];
  endfunction

  task automatic init_tab();
    logic [7:0] f [23] = '{8'h20,8'h22,8'h24,8'h25,8'h28,8'h29,8'h2A,8'h2B,8'h2E,8'h2F,8'h30,
                           8'h38,8'h39,8'h3A,8'h40,8'h41,8'h42,8'h43,8'h54,8'h56,8'h81,8'h89,8'h91};
    logic [7:0] o [23] = '{OP_ADD,OP_SUB,OP_SLT,OP_SLTU,OP_NOR,OP_AND,OP_OR,OP_XOR,OP_SLL,OP_SRL,OP_SRA,
                           OP_MUL,OP_MULH,OP_MULHU,OP_DIV,OP_MOD,OP_DIVU,OP_MODU,OP_BREAK,OP_SYSCALL,
                           OP_SLLI,OP_SRLI,OP_SRAI};
    for (int i = 0; i < 256; i++) op_tab[i] = OP_INVALID;
    for (int i = 0; i < 23; i++) begin
      op_tab[f[i]] = o[i];
      funcs[i] = f[i];
    end
  endtask

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic tick();
    bit push, pop;
    push = in_valid && (mq.size() != DEPTH) && !flush;
    pop  = (mq.size() != 0) && out_ready && !flush;
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{in_pc, in_inst});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 0; out_ready = 0; flush = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle(); in_pc = 0; in_inst = 0;
    #1;
    n_tests++; if (count !== 3'd0)    begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_tests++; if (out_ine !== 1'b0)   begin n_fail++; $display("FAIL reset_out_ine got %b exp 0", out_ine); end
    mq.delete();
    @(posedge clk); #1;
    reset = 0;
    tick();
  endtask

  task automatic test_single();
    in_valid = 1; in_pc = 32'h1C00_0000; in_inst = 32'h0010_0C41;
    tick();
    in_valid = 0;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", out_valid); end
    n_tests++; if (out_op !== OP_ADD)  begin n_fail++; $display("FAIL single_op got %0d exp %0d", out_op, OP_ADD); end
    n_tests++; if ({out_rd, out_rj, out_rk} !== {5'd1, 5'd2, 5'd3})
      begin n_fail++; $display("FAIL single_regs got %0d/%0d/%0d exp 1/2/3", out_rd, out_rj, out_rk); end
    n_tests++; if (out_src2_imm !== 1'b0) begin n_fail++; $display("FAIL single_imm got %b exp 0", out_src2_imm); end
    n_tests++; if (out_pc !== 32'h1C00_0000) begin n_fail++; $display("FAIL single_pc got %h exp 1c000000", out_pc); end
    n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", count); end
    out_ready = 1;
    tick();
    out_ready = 0;
    n_tests++; if (count !== 3'd0 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL single_pop count=%0d valid=%b exp 0/0", count, out_valid); end
  endtask

  task automatic test_fill_and_full_pop();
    logic [31:0] insts [4] = '{32'h0011_0000, 32'h0012_8000, 32'h0015_0000, 32'h002A_0000};
    logic [7:0]  exp_ops [4] = '{OP_SUB, OP_SLTU, OP_OR, OP_BREAK};
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_pc = 32'h100 + 4 * i; in_inst = insts[i];
      tick();
    end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %b exp 0", in_ready); end
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d exp 4", count); end
    n_tests++; if (out_op !== exp_ops[0]) begin n_fail++; $display("FAIL fill_head got %0d exp %0d", out_op, exp_ops[0]); end
    // Full: pop happens, new word is held off.
    in_inst = 32'h0010_0000; in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0; out_ready = 0;
    n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL fullpop_count got %0d exp 3", count); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_in_ready got %b exp 1", in_ready); end
    out_ready = 1;
    for (int i = 1; i < 4; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_op !== exp_ops[i])
        begin n_fail++; $display("FAIL drain_%0d got v=%b op=%0d exp v=1 op=%0d", i, out_valid, out_op, exp_ops[i]); end
      tick();
    end
    out_ready = 0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_shift_imm();
    in_valid = 1; in_pc = 32'h200; in_inst = 32'h0040_9443;
    tick();
    in_valid = 0;
    n_tests++; if (out_op !== OP_SLLI) begin n_fail++; $display("FAIL slli_op got %0d exp %0d", out_op, OP_SLLI); end
    n_tests++; if (out_rk !== 5'd5) begin n_fail++; $display("FAIL slli_ui5 got %0d exp 5", out_rk); end
    n_tests++; if (out_src2_imm !== 1'b1) begin n_fail++; $display("FAIL slli_imm got %b exp 1", out_src2_imm); end
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_pc = 32'h300 + 4 * i; in_inst = 32'h0010_0C41; tick();
    end
    n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got %0d exp 3", count); end
    flush = 1; in_valid = 1; out_ready = 1;
    tick();
    flush = 0; in_valid = 0; out_ready = 0;
    n_tests++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL flush_state got c=%0d v=%b r=%b exp 0/0/1", count, out_valid, in_ready); end
    tick();
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_no_enq got %0d exp 0", count); end
  endtask

  task automatic test_invalid_and_async_reset();
    logic exp_ine;
`ifdef DECODE_INE_EN
    exp_ine = 1'b1;
`else
    exp_ine = 1'b0;
`endif
    in_valid = 1; in_pc = 32'h400; in_inst = 32'hFFFF_FFFF; tick();
    in_inst = 32'h0010_0C41; tick();
    in_valid = 0;
    n_tests++; if (out_op !== OP_INVALID) begin n_fail++; $display("FAIL inv_op got %0d exp %0d", out_op, OP_INVALID); end
    n_tests++; if (out_ine !== exp_ine) begin n_fail++; $display("FAIL inv_ine got %b exp %b", out_ine, exp_ine); end
    #2; reset = 1; #1;
    n_tests++; if (count !== 3'd0 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL async_reset got c=%0d v=%b exp 0/0", count, out_valid); end
    #1; reset = 0; mq.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!(in_valid && !in_ready)) begin
        in_pc = $urandom;
        if ($urandom_range(0, 4) == 0) in_inst = $urandom;
        else in_inst = {9'd0, funcs[$urandom_range(0, 22)], 15'($urandom)};
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      tick();
      n_tests++;
      if (count !== 3'(mq.size()) || out_valid !== (mq.size() != 0) || in_ready !== (mq.size() != DEPTH))
        begin n_fail++; $display("FAIL rnd_state cyc %0d got c=%0d v=%b r=%b exp c=%0d", cyc, count, out_valid, in_ready, mq.size()); end
      if (mq.size() != 0) begin
        logic [7:0] eop;
        logic eimm, eine;
        eop  = ref_op(mq[0].inst);
        eimm = (eop == OP_SLLI) || (eop == OP_SRLI) || (eop == OP_SRAI);
`ifdef DECODE_INE_EN
        eine = (eop == OP_INVALID);
`else
        eine = 1'b0;
`endif
        n_tests++;
        if (out_op !== eop || out_src2_imm !== eimm || out_ine !== eine || out_pc !== mq[0].pc || out_inst !== mq[0].inst ||
            out_rd !== mq[0].inst[4:0] || out_rj !== mq[0].inst[9:5] || out_rk !== mq[0].inst[14:10])
          begin n_fail++; $display("FAIL rnd_head cyc %0d got op=%0d imm=%b ine=%b pc=%h inst=%h exp op=%0d imm=%b ine=%b pc=%h inst=%h",
                                   cyc, out_op, out_src2_imm, out_ine, out_pc, out_inst, eop, eimm, eine, mq[0].pc, mq[0].inst); end
      end
    end
    idle();
  endtask

  initial begin
    init_tab();
    test_reset();
    test_single();
    test_fill_and_full_pop();
    test_shift_imm();
    test_flush();
    test_invalid_and_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
